// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, scancode constants and base translation map for the PS/2 key decoder
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frameState_t;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXTENDED = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL = 8'h14;
  localparam logic [7:0] CODE_CAPS = 8'h58;
  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL = 2;
  localparam int MOD_RCTRL = 3;
  localparam int MOD_CAPS = 4;
  // Returns {valid, ascii}; each entry holds {unshifted, shifted} characters.
  function automatic logic [8:0] baseMap(input logic [7:0] code, input logic shift);
    logic [15:0] pair;
    case (code)
      8'h1C: pair = "aA"; 8'h32: pair = "bB"; 8'h21: pair = "cC"; 8'h23: pair = "dD";
      8'h24: pair = "eE"; 8'h2B: pair = "fF"; 8'h34: pair = "gG"; 8'h33: pair = "hH";
      8'h43: pair = "iI"; 8'h3B: pair = "jJ"; 8'h42: pair = "kK"; 8'h4B: pair = "lL";
      8'h3A: pair = "mM"; 8'h31: pair = "nN"; 8'h44: pair = "oO"; 8'h4D: pair = "pP";
      8'h15: pair = "qQ"; 8'h2D: pair = "rR"; 8'h1B: pair = "sS"; 8'h2C: pair = "tT";
      8'h3C: pair = "uU"; 8'h2A: pair = "vV"; 8'h1D: pair = "wW"; 8'h22: pair = "xX";
      8'h35: pair = "yY"; 8'h1A: pair = "zZ";
      8'h16: pair = "1!"; 8'h1E: pair = "2@"; 8'h26: pair = "3#"; 8'h25: pair = "4$";
      8'h2E: pair = "5%"; 8'h36: pair = "6^"; 8'h3D: pair = "7&"; 8'h3E: pair = "8*";
      8'h46: pair = "9("; 8'h45: pair = "0)";
      8'h0E: pair = "`~"; 8'h4E: pair = "-_"; 8'h55: pair = "=+"; 8'h54: pair = "[{";
      8'h5B: pair = "]}"; 8'h5D: pair = "\\|"; 8'h4C: pair = ";:"; 8'h52: pair = "'\"";
      8'h41: pair = ",<"; 8'h49: pair = ".>"; 8'h4A: pair = "/?";
      8'h5A: pair = 16'h0D0D; 8'h66: pair = 16'h0808; 8'h29: pair = 16'h2020;
      8'h0D: pair = 16'h0909; 8'h76: pair = 16'h1B1B;
      default: pair = '0;
    endcase
    return {pair != '0, shift ? pair[7:0] : pair[15:8]};
  endfunction
endpackage

// File: rtl/ps2_char_fifo.sv
// ps2_char_fifo: first-word-fall-through character queue
// Ports: Clock/Reset (sync, active-high); Push/DataIn write; Pop reads the head
// (ignored when Empty); DataOut is the head, 0 when Empty; Full/Empty status.
module ps2_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic             Full,
  output logic             Empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign Empty = wrPtr == rdPtr;
  assign Full = (wrPtr ^ rdPtr) == {1'b1, {AW{1'b0}}};
  assign doPop = Pop & ~Empty;
  // A simultaneous pop frees the head slot, so a push while full still lands.
  assign doPush = Push & (~Full | doPop);
  assign DataOut = Empty ? '0 : mem[rdPtr[AW-1:0]];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  end
  always_ff @(posedge Clock) if (doPush) mem[wrPtr[AW-1:0]] <= DataIn;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver, set-2 scancode to ASCII translator and character queue
// Ports: Clock/Reset (sync, active-high); PS2Clock/PS2Data raw keyboard lines;
// CharRead pops when CharValid; CharOut FIFO head (0 when empty); FrameError and
// Overflow one-cycle pulses; Modifiers = {CapsLock, RCtrl, LCtrl, RShift, LShift}.
// Define PS2_CTRL_CODES_EN to turn Ctrl+letter into control codes 0x01-0x1A.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2Clock,
  input  logic       PS2Data,
  input  logic       CharRead,
  output logic       CharValid,
  output logic [7:0] CharOut,
  output logic       FrameError,
  output logic       Overflow,
  output logic [4:0] Modifiers
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clkSync, dataSync;
  logic filtClk, filtDone, strobe, din, timeout, frameErrNext, byteDone;
  logic [FW-1:0] filtCnt;
  frameState_t state, stateNext;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg, rxByte, ascii, flipped;
  logic [TW-1:0] timer;
  logic byteValid, brk, ext, isBreak, isExt, isPrefix, isMod, isLetter, shiftOn, ctrlOn, emit, full, empty;
  logic [8:0] mapped;
  logic [4:0] modsNext;
  assign filtDone = (clkSync[1] != filtClk) && (filtCnt == FW'(FILTER_LEN - 1));
  assign strobe = filtDone & filtClk;
  assign din = dataSync[1];
  assign timeout = (state != IDLE) && (timer == TW'(TIMEOUT_CYCLES));
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clkSync <= '1;
      dataSync <= '1;
      filtClk <= 1'b1;
      filtCnt <= '0;
      state <= IDLE;
      bitCnt <= '0;
      shiftReg <= '0;
      timer <= '0;
      FrameError <= 1'b0;
      byteValid <= 1'b0;
      rxByte <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
      Modifiers <= '0;
      Overflow <= 1'b0;
    end else begin
      clkSync <= {clkSync[0], PS2Clock};
      dataSync <= {dataSync[0], PS2Data};
      filtCnt <= (clkSync[1] == filtClk || filtDone) ? '0 : filtCnt + 1'b1;
      if (filtDone) filtClk <= clkSync[1];
      state <= stateNext;
      bitCnt <= (state == IDLE) ? '0 : (strobe && state == DATA) ? bitCnt + 3'd1 : bitCnt;
      if (strobe && state == DATA) shiftReg <= {din, shiftReg[7:1]};
      timer <= (state == IDLE || strobe) ? '0 : timer + 1'b1;
      FrameError <= frameErrNext;
      byteValid <= byteDone;
      if (byteDone) rxByte <= shiftReg;
      if (byteValid) begin
        brk <= isBreak | (isExt & brk);
        ext <= isExt | (isBreak & ext);
      end
      Modifiers <= modsNext;
      Overflow <= emit & full & ~(CharRead & CharValid);
    end
  end
  always_comb begin
    stateNext = state;
    frameErrNext = 1'b0;
    byteDone = 1'b0;
    if (timeout) begin
      stateNext = IDLE;
      frameErrNext = 1'b1;
    end else if (strobe) begin
      case (state)
        IDLE: stateNext = din ? IDLE : DATA;
        DATA: stateNext = (bitCnt == 3'd7) ? PARITY : DATA;
        PARITY: begin
          stateNext = (^shiftReg ^ din) ? STOP : IDLE;
          frameErrNext = ~(^shiftReg ^ din);
        end
        default: begin
          stateNext = IDLE;
          byteDone = din;
          frameErrNext = ~din;
        end
      endcase
    end
  end
  always_comb begin
    isBreak = rxByte == CODE_BREAK;
    isExt = rxByte == CODE_EXTENDED;
    isPrefix = isBreak | isExt;
    isMod = rxByte inside {CODE_LSHIFT, CODE_RSHIFT, CODE_CTRL, CODE_CAPS};
    shiftOn = Modifiers[MOD_LSHIFT] | Modifiers[MOD_RSHIFT];
    ctrlOn = Modifiers[MOD_LCTRL] | Modifiers[MOD_RCTRL];
    mapped = ext ? (rxByte == 8'h5A ? 9'h10D : rxByte == 8'h4A ? 9'h12F : 9'h000) : baseMap(rxByte, shiftOn);
    isLetter = !ext && (mapped[7:0] inside {[8'h41:8'h5A], [8'h61:8'h7A]});
    // The map already applied shift; CapsLock flips letter case on top of it.
    flipped = mapped[7:0] ^ {2'b00, Modifiers[MOD_CAPS], 5'b00000};
`ifdef PS2_CTRL_CODES_EN
    ascii = !isLetter ? mapped[7:0] : ctrlOn ? {3'b000, mapped[4:0]} : flipped;
`else
    ascii = isLetter ? flipped : mapped[7:0];
`endif
    emit = byteValid && !isPrefix && !brk && !isMod && mapped[8];
    modsNext = Modifiers;
    if (byteValid && !isPrefix) begin
      if (!ext && rxByte == CODE_LSHIFT) modsNext[MOD_LSHIFT] = !brk;
      if (!ext && rxByte == CODE_RSHIFT) modsNext[MOD_RSHIFT] = !brk;
      if (rxByte == CODE_CTRL) modsNext[ext ? MOD_RCTRL : MOD_LCTRL] = !brk;
      if (!ext && !brk && rxByte == CODE_CAPS) modsNext[MOD_CAPS] = !Modifiers[MOD_CAPS];
    end
  end
  assign CharValid = ~empty;
  ps2_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) charFifo (
    .Clock(Clock),
    .Reset(Reset),
    .Push(emit),
    .Pop(CharRead),
    .DataIn(ascii),
    .DataOut(CharOut),
    .Full(full),
    .Empty(empty)
  );
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;
  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int FIFO_DEPTH = 4;
  logic Clock = 1'b0, Reset = 1'b1, PS2Clock = 1'b1, PS2Data = 1'b1, CharRead = 1'b0;
  logic CharValid, FrameError, Overflow;
  logic [7:0] CharOut;
  logic [4:0] Modifiers;
  int tests = 0, failed = 0, cyc = 0, stopCyc = 0, riseCyc = 0, errCount = 0, ovCount = 0, e0;
  logic cvPrev = 1'b0;
  logic [7:0] expQ [$];
  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .PS2Clock(PS2Clock), .PS2Data(PS2Data), .CharRead(CharRead),
    .CharValid(CharValid), .CharOut(CharOut), .FrameError(FrameError), .Overflow(Overflow), .Modifiers(Modifiers)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  always @(negedge Clock) begin
    if (CharValid && !cvPrev) riseCyc = cyc;
    cvPrev = CharValid;
    if (FrameError) errCount++;
    if (Overflow) ovCount++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask
  task automatic sendFrame(input logic [7:0] b, input bit badPar, input int nBits);
    logic [10:0] bits;
    bits = {1'b1, badPar ? ^b : ~^b, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge Clock);
      PS2Data = bits[i];
      repeat (4) @(negedge Clock);
      PS2Clock = 1'b0;
      if (i == 10) stopCyc = cyc;
      repeat (8) @(negedge Clock);
      PS2Clock = 1'b1;
      repeat (4) @(negedge Clock);
    end
    PS2Data = 1'b1;
  endtask
  task automatic sendByte(input logic [7:0] b);
    sendFrame(b, 1'b0, 11);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (CharValid && n < 16) begin
      check(tag, CharOut, expQ.size() != 0 ? 32'(expQ.pop_front()) : 32'hFFFF);
      CharRead = 1'b1;
      @(negedge Clock);
      CharRead = 1'b0;
      n++;
    end
    check({tag, "_left"}, expQ.size(), 0);
    check({tag, "_empty"}, CharValid, 0);
  endtask
  initial begin
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_valid", CharValid, 0);
    check("rst_out", CharOut, 0);
    check("rst_mods", Modifiers, 0);
    check("rst_ferr", FrameError, 0);
    check("rst_ovf", Overflow, 0);
    sendByte(8'h1C); expQ.push_back(8'h61);
    check("latency", riseCyc - stopCyc, FILTER_LEN + 3);
    drain("plain_a");
    sendByte(8'h12);
    check("lshift_set", Modifiers, 5'b00001);
    sendByte(8'h1C); expQ.push_back(8'h41);
    sendByte(8'hF0); sendByte(8'h12);
    check("lshift_clr", Modifiers, 5'b00000);
    sendByte(8'h1C); expQ.push_back(8'h61);
    drain("shift");
    sendByte(8'h58);
    check("caps_on", Modifiers, 5'b10000);
    sendByte(8'h1C); expQ.push_back(8'h41);
    sendByte(8'hF0); sendByte(8'h58);
    check("caps_break", Modifiers, 5'b10000);
    sendByte(8'h12);
    sendByte(8'h1C); expQ.push_back(8'h61);
    sendByte(8'h16); expQ.push_back(8'h21);
    sendByte(8'hF0); sendByte(8'h12);
    sendByte(8'h16); expQ.push_back(8'h31);
    sendByte(8'h58);
    check("caps_off", Modifiers, 5'b00000);
    drain("caps");
    e0 = errCount;
    sendFrame(8'h1C, 1'b1, 11);
    check("parity_err", errCount - e0, 1);
    check("parity_nochar", CharValid, 0);
    e0 = errCount;
    sendFrame(8'h1C, 1'b0, 5);
    check("timeout_early", errCount - e0, 0);
    repeat (TIMEOUT_CYCLES + 50) @(negedge Clock);
    check("timeout_err", errCount - e0, 1);
    sendByte(8'h32); expQ.push_back(8'h62);
    drain("after_timeout");
    e0 = ovCount;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      sendByte(8'h1C);
      if (i < FIFO_DEPTH) expQ.push_back(8'h61);
    end
    check("overflow", ovCount - e0, 1);
    drain("fifo_full");
    sendByte(8'hE0); sendByte(8'h4A); expQ.push_back(8'h2F);
    drain("ext_slash");
    sendByte(8'h14);
    check("lctrl", Modifiers, 5'b00100);
`ifdef PS2_CTRL_CODES_EN
    sendByte(8'h21); expQ.push_back(8'h03);
`else
    sendByte(8'h21); expQ.push_back(8'h63);
`endif
    sendByte(8'hF0); sendByte(8'h14);
    sendByte(8'hE0); sendByte(8'h14);
    check("rctrl", Modifiers, 5'b01000);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h14);
    check("rctrl_clr", Modifiers, 5'b00000);
    drain("ctrl");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver and scancode-to-ASCII translator running entirely in the system clock domain. It oversamples the keyboard's PS2Clock/PS2Data lines, validates each 11-bit frame (start, data, odd parity, stop), and tracks set-2 prefix and modifier state. Translated characters are queued in an internal FIFO for the CPU-side consumer. It sits between the keyboard pins and the RP2 CPU's character input port.

## Interface
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered PS2Clock changes level (≥2).
- TIMEOUT_CYCLES, 20000: Clock cycles without a filtered falling edge before a partial frame is abandoned.
- FIFO_DEPTH, 8: character queue depth; power of two, ≥2.
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- PS2Clock  in  1  raw keyboard clock, asynchronous.
- PS2Data  in  1  raw keyboard data, asynchronous.
- CharRead  in  1  pop request; honoured only when CharValid=1.
- CharValid  out  1  FIFO not empty.
- CharOut  out  8  FIFO head (first-word-fall-through); 0 when empty.
- FrameError  out  1  one-cycle pulse on start/parity/stop/timeout failure.
- Overflow  out  1  one-cycle pulse when a character is dropped because the FIFO is full.
- Modifiers  out  5  {CapsLock, RCtrl, LCtrl, RShift, LShift}.

## Operation
- Input path: 2-flop synchroniser on both lines, then FILTER_LEN glitch filter on the clock line; falling edge of the filtered clock = sample strobe; data sampled from synchronised PS2Data at the strobe.
- Frame FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
  - IDLE: strobe with data=0 enters DATA; data=1 is ignored (no error).
  - PARITY: checks that the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: data must be 1. On success, the byte goes to the decoder. Any failure pulses FrameError and discards the byte.
  - Any non-IDLE state with TIMEOUT_CYCLES elapsed since the last strobe: return to IDLE and pulse FrameError.
- Decoder:
  - 0xF0 sets Break; 0xE0 sets Extended. The next non-prefix byte consumes and clears both.
  - Modifier codes:
    - 0x12 = LShift, 0x59 = RShift: set on make, clear on break.
    - 0x14 = LCtrl, E0 14 = RCtrl: set on make, clear on break.
    - 0x58 toggles CapsLock on make only.
  - Modifier codes are never enqueued.
- Translation (make codes only; breaks produce nothing):
  - Letters: uppercase iff CapsLock XOR (LShift|RShift).
  - Digits and punctuation: shifted form iff LShift|RShift; CapsLock has no effect.
  - Fixed codes: 5A->0x0D, 66->0x08, 29->0x20, 0D->0x09, 76->0x1B, E0 5A->0x0D, E0 4A->0x2F.
  - Unmapped codes and other extended codes are dropped silently.
- FIFO:
  - Push when the translator emits.
  - Push while full: character dropped, Overflow pulsed, unless a pop occurs in the same cycle, in which case the push is accepted and the count is unchanged.
  - CharRead while empty is ignored.

## Timing
- Reset values: FSM IDLE, FIFO empty, CharValid=0, CharOut=0, FrameError=0, Overflow=0, Modifiers=0, Break=Extended=0, filter output=1.
- Reset mid-frame aborts the frame with no error pulse.
- Input-to-strobe latency: 2 (synchroniser) + FILTER_LEN cycles after the raw clock edge.
- Strobe of the stop bit at cycle E: byte registered at E+1, translation and push at E+2, CharValid=1 and CharOut valid at E+2 when the FIFO was empty.
- Modifiers update at E+2.
- FrameError asserts at E+1 for parity/stop errors, and the cycle after the counter reaches TIMEOUT_CYCLES for timeouts.
- Pop: CharOut shows the next entry the cycle after CharRead&&CharValid.
- Byte rate is far below FIFO bandwidth; at most one push per 11 strobes.

## Configuration
- PS2_CTRL_CODES_EN defined: with LCtrl|RCtrl held, letter makes emit 0x01–0x1A (a=0x01), independent of shift/caps; other keys are unchanged.
- Undefined: Ctrl state is tracked in Modifiers only and letters translate normally.

## Structure
- Package ps2_pkg holds:
  - frame FSM state enum;
  - scancode constants (BREAK 0xF0, EXTENDED 0xE0, modifier codes);
  - Modifiers bit indices;
  - the function mapping {code, shift} to {valid, ascii} for the base map.
- Sub-module ps2_char_fifo: parametrised FWFT FIFO (DEPTH, WIDTH=8) with push/pop/full/empty; instantiated once.

## Test plan
- Frame 0x1C, parity 0, stop 1 -> CharValid, CharOut=0x61 at E+2; CharRead -> CharValid=0.
- Bytes 12,1C,F0,12,1C -> chars 0x41 then 0x61; Modifiers[0] goes 1 then 0.
- 58 then 1C -> 0x41; then 12,1C -> 0x61 (caps XOR shift); 58 again -> Modifiers[4]=0.
- Frame 0x1C with parity 1 -> FrameError one cycle, no char. Frame stopping after 4 data bits -> FrameError at timeout, then a clean 0x32 frame -> 0x62.
- FIFO_DEPTH=4, five 1C makes without reads -> four 0x61 queued, one Overflow pulse; E0 4A -> 0x2F after draining.
- 14,21 -> 0x03 with PS2_CTRL_CODES_EN, 0x63 without; E0 14 sets Modifiers[3] only.
